// File: rtl/reconf_tile_accum.sv
// reconf_tile_accum: sums a configured number of fp16 partial dot products
// from the multiply/adder-tree tile into a single result.
// Flow: IDLE (accept a job) -> ACCUM (one partial per cycle) -> DONE (hold
// the result until the consumer takes it).
// The fp16 add is combinational and always rounds to nearest-even.
// Optional build macro ACCUM_STATUS_EN: when defined, the adder's
// {NV,DZ,OF,UF,NX} flags are ORed into a sticky register and driven on
// out_status_o. When undefined, out_status_o is tied to zero.
module reconf_tile_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_CHUNKS = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cfg_valid_i,
  output logic                                cfg_ready_o,
  input  logic [$clog2(MAX_CHUNKS+1)-1:0]     cfg_len_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [DATA_WIDTH-1:0]               in_scal_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [DATA_WIDTH-1:0]               out_scal_o,
  output logic [4:0]                          out_status_o,
  output logic                                busy_o
);
  localparam int CNT_W = $clog2(MAX_CHUNKS+1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // fp16 add, RNE. Returns {status[4:0], result[15:0]}.
  // Status bit order is {NV,DZ,OF,UF,NX}.
  // Specials are resolved first. Finite operands are then aligned with 3
  // extra bits (guard, round, jammed sticky) below the 11-bit significand.
  function automatic logic [20:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic        a_nan, b_nan, a_inf, b_inf, sgn, sub, g, r, st, nx, inc;
    logic [5:0]  ex, ey;
    logic [14:0] mx, my, mask, s;
    logic [6:0]  e;
    logic [11:0] mr;
    int          d;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    if (a_nan || b_nan)
      // Only a signalling NaN (quiet bit clear) raises invalid.
      return {(a_nan && !a[9]) || (b_nan && !b[9]), 4'b0, 16'h7E00};
    if (a_inf && b_inf && (a[15] != b[15]))
      return {5'b10000, 16'h7E00};
    if (a_inf) return {5'b0, a};
    if (b_inf) return {5'b0, b};
    // Order by magnitude so the subtraction below never goes negative.
    if (a[14:0] >= b[14:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    // A subnormal uses exponent 1 with no hidden bit.
    ex  = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
    ey  = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
    mx  = {1'b0, (x[14:10] != 5'd0), x[9:0], 3'b000};
    my  = {1'b0, (y[14:10] != 5'd0), y[9:0], 3'b000};
    d   = int'(ex) - int'(ey);
    mask = (d >= 15) ? '1 : ((15'd1 << d) - 15'd1);
    // Bits shifted out of the smaller operand are jammed into its LSB.
    my  = (d >= 15) ? 15'd0 : (my >> d);
    my[0] = my[0] | (|({1'b0, y[9:0] != 10'd0 || y[14:10] != 5'd0, y[9:0], 3'b000} & mask));
    sub = x[15] ^ y[15];
    s   = sub ? (mx - my) : (mx + my);
    // An exact zero from opposite signs is +0 under RNE.
    sgn = (sub && s == 15'd0) ? 1'b0 : x[15];
    e   = {1'b0, ex};
    if (s[14]) begin
      s = {1'b0, s[14:1]} | {14'd0, s[0]};
      e = e + 7'd1;
    end
    // Left-normalise after cancellation. Stop at exponent 1 (subnormal range).
    for (int i = 0; i < 14; i++) begin
      if (!s[13] && e > 7'd1) begin
        s = s << 1;
        e = e - 7'd1;
      end
    end
    g   = s[2];
    r   = s[1];
    st  = s[0];
    nx  = g | r | st;
    inc = g & (r | st | s[3]);
    mr  = {1'b0, s[13:3]} + {11'd0, inc};
    if (mr[11]) begin
      mr = mr >> 1;
      e  = e + 7'd1;
    end
    if (e >= 7'd31)
      return {5'b00101, sgn, 5'h1F, 10'h0};
    // A hidden bit produced by rounding carries a subnormal into exponent 1.
    return {3'b000, !mr[10] && nx, nx, sgn, (mr[10] ? e[4:0] : 5'd0), mr[9:0]};
  endfunction

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   acc;
  logic [CNT_W-1:0]        cnt, len, len_clamp;
  logic                    hs;
  logic [20:0]             add_full;

  assign len_clamp = (cfg_len_i > CNT_W'(MAX_CHUNKS)) ? CNT_W'(MAX_CHUNKS) : cfg_len_i;
  assign hs        = in_valid_i & in_ready_o;
  assign add_full  = fp16_add(acc, in_scal_i);
  assign out_scal_o = acc;
  assign busy_o     = (state != IDLE);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    cfg_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) state_nxt = (len_clamp == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready_o = 1'b1;
        if (hs && cnt == len - CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator and chunk counter. The first partial is loaded verbatim,
  // with no add, so -0 and NaN payloads pass through untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc <= '0;
      cnt <= '0;
      len <= '0;
    end else if (state == IDLE && cfg_valid_i) begin
      cnt <= '0;
      len <= len_clamp;
      if (len_clamp == '0) acc <= '0;
    end else if (hs) begin
      acc <= (cnt == '0) ? in_scal_i : add_full[DATA_WIDTH-1:0];
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef ACCUM_STATUS_EN
  logic [4:0] status;
  // Sticky flags: cleared on job accept, ORed on every real add.
  always_ff @(posedge clk_i) begin
    if (rst_i)                           status <= '0;
    else if (state == IDLE && cfg_valid_i) status <= '0;
    else if (hs && cnt != '0)            status <= status | add_full[20:16];
  end
  assign out_status_o = status;
`else
  logic [4:0] unused_status;
  assign unused_status = add_full[20:16];
  assign out_status_o  = 5'b0;
`endif

endmodule

// File: tb/tb_reconf_tile_accum.sv
// Scoreboard bench for reconf_tile_accum. Each job's expected result is
// queued when the job is issued. A negedge monitor pops and compares on
// every output handshake.
module tb_reconf_tile_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [6:0]  cfg_len;
  logic        in_valid, in_ready;
  logic [15:0] in_scal;
  logic        out_valid, out_ready;
  logic [15:0] out_scal;
  logic [4:0]  out_status;
  logic        busy;

  typedef struct packed {logic [15:0] scal; logic [4:0] status;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

`ifdef ACCUM_STATUS_EN
  localparam logic [4:0] NV_EXP = 5'b10000;
`else
  localparam logic [4:0] NV_EXP = 5'b00000;
`endif

  reconf_tile_accum dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_len_i(cfg_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_scal_i(in_scal),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_scal_o(out_scal),
    .out_status_o(out_status), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("out_scal", {16'd0, out_scal}, {16'd0, mon_e.scal});
        chk("out_status", {27'd0, out_status}, {27'd0, mon_e.status});
        n_out++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input int len);
    int n = 0;
    while (!cfg_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("cfg_ready_timeout", 32'd0, 32'd1);
    cfg_valid = 1'b1;
    cfg_len   = 7'(len);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_part(input logic [15:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_scal  = v;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0; in_valid = 1'b0; in_scal = '0; out_ready = 1'b1;
    tick(); tick();
    // Reset state.
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_scal",  {16'd0, out_scal},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    rst = 1'b0;
    tick();

    // Basic sum: 1+2+3 = 6.
    q.push_back('{16'h4600, 5'b0});
    send_cfg(3);
    chk("accum_busy", {31'd0, busy}, 32'd1);
    send_part(16'h3C00); send_part(16'h4000); send_part(16'h4200);
    chk("basic_latency", {31'd0, out_valid}, 32'd1);
    tick();

    // Single partial passes through without an add.
    q.push_back('{16'hBC00, 5'b0});
    send_cfg(1);
    send_part(16'hBC00);
    tick();

    // Zero-length job: result 0 next cycle, no input consumed.
    q.push_back('{16'h0000, 5'b0});
    send_cfg(0);
    chk("zero_out_valid", {31'd0, out_valid}, 32'd1);
    chk("zero_in_ready",  {31'd0, in_ready},  32'd0);
    tick();
    chk("zero_idle_in_ready", {31'd0, in_ready}, 32'd0);

    // Backpressure with a gap in in_valid.
    out_ready = 1'b0;
    q.push_back('{16'h3C00, 5'b0});
    send_cfg(2);
    send_part(16'h3800);
    tick();
    send_part(16'h3800);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_scal",  {16'd0, out_scal},  32'h3C00);
      chk("bp_cfg_ready", {31'd0, cfg_ready}, 32'd0);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_busy",  {31'd0, busy},      32'd0);

    // Reset mid-job, then a fresh job.
    send_cfg(4);
    send_part(16'h3C00); send_part(16'h3C00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_scal",  {16'd0, out_scal},  32'd0);
    chk("mid_rst_status",    {27'd0, out_status}, 32'd0);
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    q.push_back('{16'h4000, 5'b0});
    send_cfg(1);
    send_part(16'h4000);
    tick();

    // inf + -inf gives canonical NaN, invalid when flags are built.
    q.push_back('{16'h7E00, NV_EXP});
    send_cfg(2);
    send_part(16'h7C00); send_part(16'hFC00);
    tick();

    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    chk("queue_drained", q.size(), 32'd0);
    chk("outputs_seen", n_out, 32'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
